// File: rtl/wt_sched.sv
// Message-granular round-robin arbiter sharing one W(t) generator between NUM_PORTS
// padded-block producers. A grant is held until the owner's tlast beat is accepted.
module wt_sched #(
  parameter int NUM_PORTS            = 4,
  parameter int C_S_AXIS_DATA_WIDTH  = 512,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int PORT_ID_POS          = 48
) (
  input  logic                                      axis_aclk,
  input  logic                                      axis_resetn,
  input  logic [NUM_PORTS*C_S_AXIS_DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic [NUM_PORTS*C_S_AXIS_TUSER_WIDTH-1:0] s_axis_tuser,
  input  logic [NUM_PORTS-1:0]                      s_axis_tvalid,
  output logic [NUM_PORTS-1:0]                      s_axis_tready,
  input  logic [NUM_PORTS-1:0]                      s_axis_tlast,
  input  logic [NUM_PORTS-1:0]                      port_en,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]            m_axis_tdata,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]           m_axis_tuser,
  output logic                                      m_axis_tvalid,
  input  logic                                      m_axis_tready,
  output logic                                      m_axis_tlast,
  output logic [NUM_PORTS-1:0]                      grant,
  output logic                                      busy
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int DW    = C_S_AXIS_DATA_WIDTH;
  localparam int UW    = C_S_AXIS_TUSER_WIDTH;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t               state, state_nxt;
  logic [IDX_W-1:0]     owner, owner_nxt;
  logic [IDX_W-1:0]     last_grant, last_grant_nxt;
  logic [IDX_W-1:0]     cand, pick;
  logic                 pick_vld;
  logic                 owner_done;
  logic [NUM_PORTS-1:0] req;

  assign req        = s_axis_tvalid & port_en;
  assign owner_done = (state == LOCKED) && s_axis_tvalid[owner] && m_axis_tready
                      && s_axis_tlast[owner];

  // Scan starts just after the previous owner, so that owner is considered last.
  // NOTE: every variable driven here gets a default first, so no latch can be inferred.
  always_comb begin
    cand     = '0;
    pick     = last_grant;
    pick_vld = 1'b0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      cand = IDX_W'((int'(last_grant) + i) % NUM_PORTS);
      if (!pick_vld && req[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_grant_nxt = last_grant;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          state_nxt = LOCKED;
          owner_nxt = pick;
        end
      end
      LOCKED: begin
        if (owner_done) begin
          state_nxt      = IDLE;
          last_grant_nxt = owner;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments make every register update from pre-edge values.
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      state      <= IDLE;
      owner      <= '0;
      last_grant <= IDX_W'(NUM_PORTS - 1);
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  // Pure mux of the owner's stream: payload stability follows from the source.
  always_comb begin
    s_axis_tready = '0;
    grant         = '0;
    busy          = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tuser  = '0;
    if (state == LOCKED) begin
      grant[owner]         = 1'b1;
      busy                 = 1'b1;
      s_axis_tready[owner] = m_axis_tready;
      m_axis_tvalid        = s_axis_tvalid[owner];
      m_axis_tlast         = s_axis_tlast[owner];
      m_axis_tdata         = s_axis_tdata[int'(owner)*DW +: DW];
      m_axis_tuser         = s_axis_tuser[int'(owner)*UW +: UW];
      m_axis_tuser[PORT_ID_POS +: 3] = 3'(owner);
    end
  end

endmodule

// File: doc/wt_sched.md
Name: wt_sched

Overview:
- Message-granular round-robin arbiter that shares one W(t) generator between NUM_PORTS padded-block producers.
- Sits between the padder outputs and the single W(t) unit's 512-bit AXI-Stream slave port.
- Grants one requester and holds the grant until that requester's last block (tlast) is accepted, so a multi-block message is never interleaved.
- Tags the forwarded tuser with the granted port index so downstream can route the digest back.

Parameters:
- NUM_PORTS, 4, number of requesters (2..8).
- C_S_AXIS_DATA_WIDTH, 512, per-port and output block width.
- C_S_AXIS_TUSER_WIDTH, 128, per-port and output tuser width.
- PORT_ID_POS, 48, LSB of the 3-bit port-id field written into the output tuser.

Ports:
- axis_aclk  in  1  clock.
- axis_resetn  in  1  reset, asynchronous, active-low.
- s_axis_tdata  in  NUM_PORTS*C_S_AXIS_DATA_WIDTH  flattened; port k occupies slice k.
- s_axis_tuser  in  NUM_PORTS*C_S_AXIS_TUSER_WIDTH  flattened per port.
- s_axis_tvalid  in  NUM_PORTS  per-port valid.
- s_axis_tready  out  NUM_PORTS  per-port ready.
- s_axis_tlast  in  NUM_PORTS  per-port last block of message.
- port_en  in  NUM_PORTS  per-port arbitration enable.
- m_axis_tdata  out  C_S_AXIS_DATA_WIDTH  to W(t) unit.
- m_axis_tuser  out  C_S_AXIS_TUSER_WIDTH  to W(t) unit.
- m_axis_tvalid  out  1
- m_axis_tready  in  1
- m_axis_tlast  out  1
- grant  out  NUM_PORTS  one-hot current owner; all zero when idle.
- busy  out  1  high while a grant is held.

Behaviour:
- Reset:
  - Asserting axis_resetn low immediately clears all state (asynchronous): state=IDLE, grant=0, busy=0, last_grant=NUM_PORTS-1.
  - All s_axis_tready=0, m_axis_tvalid=0.
  - Reset asserted mid-message drops the message; no flush.
- Eligibility: req[k] = s_axis_tvalid[k] & port_en[k].
- State IDLE:
  - All outputs quiet; m_axis_tvalid=0.
  - If any req is set, pick the first k scanning last_grant+1, last_grant+2, … modulo NUM_PORTS.
  - Next cycle: grant<=onehot(k), busy<=1, state<=LOCKED.
  - Arbitration latency is 1 cycle.
- State LOCKED (owner g):
  - m_axis_tdata, m_axis_tvalid and m_axis_tlast are combinational pass-through of port g.
  - m_axis_tuser = port g tuser with bits [PORT_ID_POS+2:PORT_ID_POS] replaced by g.
  - s_axis_tready[g] = m_axis_tready; every other s_axis_tready = 0.
  - A beat is accepted when s_axis_tvalid[g] & m_axis_tready.
  - On an accepted beat with s_axis_tlast[g]=1: next cycle state<=IDLE, grant<=0, busy<=0, last_grant<=g.
  - The re-arbitration IDLE cycle is mandatory, so there is a minimum 1-cycle bubble between messages.
- Deassertion cases while LOCKED:
  - Owner deasserting s_axis_tvalid mid-message keeps the grant.
  - Clearing port_en[g] mid-message keeps the grant; port_en is sampled only in IDLE.
- Fairness:
  - Strict round-robin at message granularity.
  - A port that just finished is lowest priority in the next arbitration.
  - Wrap-around from NUM_PORTS-1 to 0.
- Single requester: the same port is re-granted after every 1-cycle IDLE bubble.
- No payload buffering: AXI-Stream rules hold end to end, with tdata/tuser stable while valid and not ready because they are a pure mux of a stable source.
- Simultaneous events: a new tvalid arriving in the same cycle as the owner's tlast handshake is not considered until the IDLE cycle.

Test Plan:
- Reset mid-message: port 0 granted and 1 of 2 beats sent; assert axis_resetn=0 between clock edges → grant=0, busy=0, all readies 0 before the next edge. After release, port 1 requests → port 1 is granted (last_grant reset to 3, so scan starts at 0, but port 0 is now idle).
- Single port: port 2 sends a 3-block message (beats 0..2, tlast on beat 2), m_axis_tready=1 → grant=4'b0100 one cycle after tvalid. Output carries the 3 beats unchanged, with tuser[50:48]=3'd2. busy falls the cycle after beat 2.
- Contention: all 4 ports valid from reset, each with a 2-block message → grant order is 0,1,2,3. Each message is contiguous, each is followed by exactly 1 idle cycle, and the total is 4×2+4 arbitration cycles = 12 cycles.
- Backpressure: m_axis_tready toggles 1,0,0,1 during port 1's message → s_axis_tready[1] mirrors it, other ports' tready stay 0, and m_axis_tdata is stable across the stall.
- Enable masking: port_en=4'b1011 with all ports valid → port 2 is never granted. Clearing port_en[1] while port 1 is mid-message does not drop port 1 before its tlast.
- Wrap and fairness: ports 3 and 0 continuously requesting with 1-block messages → grants alternate 3,0,3,0.
